// File: rtl/seqcheck_pkg.sv
// Shared defaults for the serial pattern detector family.
package seqcheck_pkg;
  localparam int         SEQ_LEN_DEF   = 6;
  localparam logic [5:0] SEQ_PAT_DEF   = 6'b101011;
  localparam int         SEQ_CNT_W_DEF = 8;
endpackage

// File: rtl/seqcheck_shreg.sv
// Bit history shift register: q[0] holds the newest accepted bit, q[W-1] the oldest.
// Shifts only when en is high; clear zeroes it synchronously.
module seqcheck_shreg
  import seqcheck_pkg::*;
#(
  parameter int W = SEQ_LEN_DEF - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clear,
  input  logic         d,
  output logic [W-1:0] q
);

  // Built at W+1 bits so that W == 1 needs no special-case slice.
  logic [W:0] nxt;
  assign nxt = {q, d};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= nxt[W-1:0];
    end
  end

endmodule

// File: rtl/seqcheck_param.sv
// Serial pattern detector: compares {hist,in} with a loadable pattern under a care-mask,
// giving a registered one-cycle match pulse and a saturating match count.
module seqcheck_param
  import seqcheck_pkg::*;
#(
  parameter int             LEN     = SEQ_LEN_DEF,
  parameter logic [LEN-1:0] PATTERN = LEN'(SEQ_PAT_DEF),
  parameter int             CNT_W   = SEQ_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic             clear,
  input  logic             cfg_we,
  input  logic [LEN-1:0]   pat_in,
  input  logic [LEN-1:0]   mask_in,
  input  logic             overlap,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic [LEN-2:0]   hist
);

  localparam int            FW        = $clog2(LEN);
  localparam logic [FW-1:0] FILL_FULL = FW'(LEN - 1);

  logic [LEN-1:0] pat;
  logic [LEN-1:0] mask;
  logic [LEN-1:0] win;
  logic [FW-1:0]  fill;
  logic           hit;
  logic           full;
  logic           match;

  // hist[LEN-2] is the oldest bit, so plain concatenation already puts oldest at the MSB.
  assign win   = {hist, in};
  assign hit   = ((win ^ pat) & mask) == '0;
  assign full  = (fill == FILL_FULL);
  assign match = en && hit && full;

  seqcheck_shreg #(.W(LEN - 1)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clear (clear),
    .d     (in),
    .q     (hist)
  );

  // Config is independent of clear; the compare above always sees the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat  <= PATTERN;
      mask <= '1;
    end else if (cfg_we) begin
      pat  <= pat_in;
      mask <= mask_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill      <= '0;
      out       <= 1'b0;
      match_cnt <= '0;
    end else if (clear) begin
      fill      <= '0;
      out       <= 1'b0;
      match_cnt <= '0;
    end else if (en) begin
      out <= match;
      if (match && match_cnt != '1) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
      // Non-overlapping mode discards the whole window once it has matched.
      if (match && !overlap) begin
        fill <= '0;
      end else if (!full) begin
        fill <= fill + FW'(1);
      end
    end else begin
      out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seqcheck_param.sv
// Directed-vector bench for seqcheck_param; a second instance with a 2-bit counter covers saturation.
module tb_seqcheck_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       in;
  logic       en;
  logic       clear;
  logic       cfg_we;
  logic [5:0] pat_in;
  logic [5:0] mask_in;
  logic       overlap;

  logic       out_a;
  logic [7:0] cnt_a;
  logic [4:0] hist_a;
  logic       out_s;
  logic [1:0] cnt_s;
  logic [4:0] hist_s;

  int nvec = 0;
  int nmis = 0;
  int pulses;

  always #5 clk = ~clk;

  seqcheck_param dut (
    .clk(clk), .rst(rst), .in(in), .en(en), .clear(clear), .cfg_we(cfg_we),
    .pat_in(pat_in), .mask_in(mask_in), .overlap(overlap),
    .out(out_a), .match_cnt(cnt_a), .hist(hist_a)
  );

  seqcheck_param #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in(in), .en(en), .clear(clear), .cfg_we(cfg_we),
    .pat_in(pat_in), .mask_in(mask_in), .overlap(overlap),
    .out(out_s), .match_cnt(cnt_s), .hist(hist_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic b, input logic e, input logic c, input logic w,
                     input logic [5:0] p, input logic [5:0] m);
    @(negedge clk);
    in = b; en = e; clear = c; cfg_we = w; pat_in = p; mask_in = m;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic b, input logic e);
    cyc(b, e, 1'b0, 1'b0, 6'd0, 6'd0);
  endtask

  // Feeds n bits MSB first, counting output pulses along the way.
  task automatic feed(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(bits[i], 1'b1);
      pulses += int'(out_a);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in = 1'b0; en = 1'b0; clear = 1'b0; cfg_we = 1'b0;
    pat_in = '0; mask_in = '0; overlap = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_hist", hist_a, 0);
    chk("rst_cnt_sat", cnt_s, 0);
    @(negedge clk);
    rst = 1'b1;

    // 1: basic detection, latency of one edge
    pulses = 0;
    feed(32'b10101, 5);
    chk("t1_pre", pulses, 0);
    step(1'b1, 1'b1);
    chk("t1_out", out_a, 1);
    chk("t1_cnt", cnt_a, 1);
    chk("t1_hist", hist_a, 5'b01011);
    step(1'b0, 1'b0);
    chk("t1_en_low", out_a, 0);

    // 2: overlapping vs non-overlapping on a stream with a shared bit
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0);
    pulses = 0;
    feed(32'b10101101011, 11);
    chk("t2_ovl_pulses", pulses, 2);
    chk("t2_ovl_last", out_a, 1);
    chk("t2_ovl_cnt", cnt_a, 2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0);
    overlap = 1'b0;
    pulses = 0;
    feed(32'b10101101011, 11);
    chk("t2_nov_pulses", pulses, 1);
    chk("t2_nov_last", out_a, 0);
    chk("t2_nov_cnt", cnt_a, 1);

    // 3: mask=0 with clear+cfg together; fill gate holds off the first five bits
    overlap = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 6'b000000, 6'b000000);
    pulses = 0;
    feed(32'b01101, 5);
    chk("t3_fill_gate", pulses, 0);
    step(1'b1, 1'b1);
    chk("t3_first", out_a, 1);
    step(1'b0, 1'b1);
    chk("t3_second", out_a, 1);
    chk("t3_cnt", cnt_a, 2);

    // 4: en gaps inside the pattern
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 6'b101011, 6'b111111);
    pulses = 0;
    feed(32'b101, 3);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("t4_gap_out", out_a, 0);
    end
    feed(32'b011, 3);
    chk("t4_pulses", pulses, 1);
    chk("t4_out", out_a, 1);
    chk("t4_cnt", cnt_a, 1);
    step(1'b0, 1'b0);
    chk("t4_after_gap", out_a, 0);
    chk("t4_cnt_hold", cnt_a, 1);

    // 5: config write on the completing edge uses the old pattern
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0);
    feed(32'b10101, 5);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 6'b111000, 6'b111111);
    chk("t5_old_pat", out_a, 1);
    pulses = 0;
    feed(32'b111000, 6);
    chk("t5_new_pulses", pulses, 1);
    chk("t5_new_out", out_a, 1);
    chk("t5_cnt", cnt_a, 2);

    // 6: counter saturation, clear, async reset incl. config
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 6'b000000, 6'b000000);
    feed(32'b0, 10);
    chk("t6_cnt_sat", cnt_s, 3);
    chk("t6_cnt_wide", cnt_a, 5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0);
    chk("t6_clr_cnt", cnt_s, 0);
    chk("t6_clr_hist", hist_a, 0);
    chk("t6_clr_out", out_a, 0);
    feed(32'b110111, 6);
    chk("t6_pre_rst_out", out_a, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_arst_out", out_a, 0);
    chk("t6_arst_cnt", cnt_a, 0);
    chk("t6_arst_hist", hist_a, 0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    feed(32'b000000, 6);
    chk("t6_mask_restored", pulses, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0);
    feed(32'b101011, 6);
    chk("t6_pat_restored", out_a, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
